// File: rtl/mux_n_skid.sv
// mux_n_skid: NUM_IN:1 registered word mux with valid/ready handshake and a 2-entry skid buffer.
// Define MUXN_SEL_CHECK_EN to add the sticky sel_err output for out-of-range selects.
module mux_n_skid #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        result,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef MUXN_SEL_CHECK_EN
  ,
  output logic                     sel_err
`endif
);
  logic [DATA_W-1:0] r_q, r_d, s_q, s_d, word;
  logic r_vld_q, r_vld_d, s_vld_q, s_vld_d, rdy_q, rdy_d, acc, drn, sel_bad;
  // Out-of-range selects fall back to input 0.
  assign sel_bad = 32'(sel) >= NUM_IN;
  assign word = sel_bad ? data_in[DATA_W-1:0] : data_in[sel*DATA_W +: DATA_W];
  assign acc = in_valid & rdy_q;
  assign drn = r_vld_q & out_ready;
  always_comb begin
    r_d = r_q;
    s_d = s_q;
    r_vld_d = r_vld_q;
    s_vld_d = s_vld_q;
    if (s_vld_q) begin
      if (drn) begin
        r_d = s_q;
        s_vld_d = 1'b0;
      end
    end else if (r_vld_q) begin
      if (acc && drn) r_d = word;
      else if (acc) begin
        s_d = word;
        s_vld_d = 1'b1;
      end else if (drn) r_vld_d = 1'b0;
    end else if (acc) begin
      r_d = word;
      r_vld_d = 1'b1;
    end
    rdy_d = !s_vld_d;
  end
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_q <= '0;
      s_q <= '0;
      r_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      r_q <= r_d;
      s_q <= s_d;
      r_vld_q <= r_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q <= rdy_d;
    end
  end
  assign in_ready = rdy_q;
  assign out_valid = r_vld_q;
  assign result = r_q;
`ifdef MUXN_SEL_CHECK_EN
  logic err_q, err_d;
  assign err_d = err_q | (acc & sel_bad);
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign sel_err = err_q;
`endif
endmodule

// File: tb/tb_mux_n_skid.sv
// tb_mux_n_skid: scoreboard bench; driver pushes expected words on accept, monitor pops on each drain.
// A second 5-input instance exercises out-of-range select handling (and sel_err when MUXN_SEL_CHECK_EN is set).
module tb_mux_n_skid;
  localparam int N = 4;
  localparam int W = 32;
  logic clock = 1'b0;
  logic aclr_n = 1'b0;
  logic [N*W-1:0] data_in = '0;
  logic [1:0] sel = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] result;
  logic [39:0] d5 = '0;
  logic [2:0] s5 = '0;
  logic v5 = 1'b0, ir5, ov5;
  logic [7:0] res5;
`ifdef MUXN_SEL_CHECK_EN
  logic err5;
`endif
  int checks = 0, errors = 0, occ = 0;
  logic [W-1:0] q[$];
  logic [N*W-1:0] stream = {32'hD3, 32'hC2, 32'hB1, 32'hA0};

  always #5 clock = ~clock;

  mux_n_skid #(.DATA_W(W), .NUM_IN(N)) dut (
    .clock(clock), .aclr_n(aclr_n), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_skid #(.DATA_W(8), .NUM_IN(5)) u5 (
    .clock(clock), .aclr_n(aclr_n), .data_in(d5), .sel(s5), .in_valid(v5),
    .in_ready(ir5), .result(res5), .out_valid(ov5), .out_ready(1'b1)
`ifdef MUXN_SEL_CHECK_EN
    , .sel_err(err5)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_word(input logic [N*W-1:0] d, input int s);
    return (s < N) ? d[s*W +: W] : d[W-1:0];
  endfunction

  // One cycle: check state left by the last edge, then present the next inputs.
  task automatic step(input logic v, input int s, input logic [N*W-1:0] d, input logic r, output logic acc);
    @(negedge clock); #2;
    chk("out_valid", out_valid, occ > 0);
    chk("in_ready", in_ready, occ < 2);
    if (occ > 0) chk("result_hold", result, q[0]);
    in_valid = v; sel = s[1:0]; data_in = d; out_ready = r;
    acc = v && occ < 2;
    if (acc) q.push_back(ref_word(d, s));
    occ = occ - ((occ > 0 && r) ? 1 : 0) + (acc ? 1 : 0);
  endtask

  task automatic send(input int s, input logic [N*W-1:0] d, input logic r);
    logic a;
    int n = 0;
    do begin
      step(1'b1, s, d, r, a);
      n++;
    end while (!a && n < 10);
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic a;
    int n = 0;
    while (occ > 0 && n < 10) begin
      step(1'b0, 0, '0, 1'b1, a);
      n++;
    end
    step(1'b0, 0, '0, 1'b1, a);
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    aclr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; v5 = 1'b0;
    q.delete(); occ = 0;
    repeat (3) @(negedge clock);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef MUXN_SEL_CHECK_EN
    chk("rst_sel_err", err5, 0);
`endif
    aclr_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock); #4;
      if (aclr_n && out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", result, 32'hDEAD_BEEF);
        else chk("drain_word", result, q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic a;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, i % 4, stream, 1'b1, a);
    drain();
    send(1, stream, 1'b0);
    send(2, stream, 1'b0);
    step(1'b1, 3, stream, 1'b0, a);
    chk("bp_third_refused", a, 0);
    send(3, stream, 1'b1);
    drain();
    for (int i = 0; i < 20; i++)
      step(1'b1, i % 4, {$urandom, $urandom, $urandom, $urandom}, 1'(i % 2), a);
    drain();
    send(0, {4{32'hEEEE_0001}}, 1'b0);
    send(1, {4{32'hEEEE_0002}}, 1'b0);
    @(negedge clock); #1;
    aclr_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    q.delete(); occ = 0;
    repeat (2) @(negedge clock);
    #2;
    aclr_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 1'b1, a);
    for (int i = 0; i < 4; i++) send(i, {32'h5003, 32'h5002, 32'h5001, 32'h5000}, 1'b1);
    drain();
    for (int i = 0; i < 300; i++)
      step($urandom % 4 != 0, int'($urandom % 4), {$urandom, $urandom, $urandom, $urandom},
           $urandom % 3 != 0, a);
    drain();
    chk("queue_empty", q.size(), 0);
    d5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h5A};
    v5 = 1'b0; s5 = 3'd7;
    step(1'b0, 0, '0, 1'b1, a);
    chk("u5_ready", ir5, 1);
    chk("u5_idle", ov5, 0);
    v5 = 1'b1; s5 = 3'd2;
    step(1'b0, 0, '0, 1'b1, a);
    v5 = 1'b0;
    chk("u5_in_range", res5, 8'h22);
    chk("u5_valid", ov5, 1);
`ifdef MUXN_SEL_CHECK_EN
    chk("u5_err_clean", err5, 0);
`endif
    v5 = 1'b1; s5 = 3'd6;
    step(1'b0, 0, '0, 1'b1, a);
    v5 = 1'b0; s5 = 3'd7;
    chk("u5_oob_input0", res5, 8'h5A);
    chk("u5_oob_valid", ov5, 1);
`ifdef MUXN_SEL_CHECK_EN
    chk("u5_err_set", err5, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, '0, 1'b1, a);
      chk("u5_err_sticky", err5, 1);
    end
`endif
    do_reset();
    step(1'b0, 0, '0, 1'b1, a);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
